// File: rtl/ldm_agen_if.sv
// Bundle between the LDM/STM address generator, its decode/sequencer neighbours and the memory stage.
// The master drives the launch and sequencer inputs; the slave is the address generator itself.
interface ldm_agen_if #(
  parameter int AW = 32
);
  logic          start;
  logic [15:0]   reglist;
  logic [AW-1:0] base;
  logic          p_bit;
  logic          u_bit;
  logic          w_bit;
  logic          l_bit;
  logic          flush;
  logic [3:0]    seq_cur;
  logic          seq_busy;

  logic [15:0]   seq_bits;
  logic          seq_en;
  logic          busy;
  logic          xfer_valid;
  logic [AW-1:0] xfer_addr;
  logic [3:0]    xfer_reg;
  logic          xfer_load;
  logic          xfer_last;
  logic          wb_en;
  logic [AW-1:0] wb_val;
  logic          done;

  modport master (
    output start, reglist, base, p_bit, u_bit, w_bit, l_bit, flush, seq_cur, seq_busy,
    input  seq_bits, seq_en, busy, xfer_valid, xfer_addr, xfer_reg, xfer_load, xfer_last,
           wb_en, wb_val, done
  );

  modport slave (
    input  start, reglist, base, p_bit, u_bit, w_bit, l_bit, flush, seq_cur, seq_busy,
    output seq_bits, seq_en, busy, xfer_valid, xfer_addr, xfer_reg, xfer_load, xfer_last,
           wb_en, wb_val, done
  );
endinterface

// File: rtl/ldm_agen.sv
// LDM/STM block-transfer address generator: latches the request, computes the lowest word address,
// pairs it with each sequencer register index in ascending order, then reports base writeback.
module ldm_agen #(
  parameter int AW = 32
) (
  input logic       clk,
  input logic       reset_n,
  ldm_agen_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_XFER, S_WB} state_e;

  localparam logic [AW-1:0] WORD = AW'(4);

  state_e        state_q, state_d;
  logic [15:0]   reglist_q, reglist_d;
  logic [AW-1:0] base_q, base_d;
  logic          p_q, p_d, u_q, u_d, w_q, w_d, l_q, l_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] wb_val_q, wb_val_d;
  logic [4:0]    cnt_q, cnt_d;

  logic [4:0]    n_regs;
  logic [AW-1:0] four_n;
  logic          xfer_go;

  always_comb begin
    n_regs = '0;
    for (int i = 0; i < 16; i++) n_regs = n_regs + {4'd0, reglist_q[i]};
  end

  assign four_n = AW'({n_regs, 2'b00});

  // NOTE: non-blocking assignments here so every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      reglist_q <= '0;
      base_q    <= '0;
      p_q       <= 1'b0;
      u_q       <= 1'b0;
      w_q       <= 1'b0;
      l_q       <= 1'b0;
      addr_q    <= '0;
      wb_val_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      reglist_q <= reglist_d;
      base_q    <= base_d;
      p_q       <= p_d;
      u_q       <= u_d;
      w_q       <= w_d;
      l_q       <= l_d;
      addr_q    <= addr_d;
      wb_val_q  <= wb_val_d;
      cnt_q     <= cnt_d;
    end
  end

  // NOTE: every variable gets a hold default first so no path through the case infers a latch.
  always_comb begin
    state_d   = state_q;
    reglist_d = reglist_q;
    base_d    = base_q;
    p_d       = p_q;
    u_d       = u_q;
    w_d       = w_q;
    l_d       = l_q;
    addr_d    = addr_q;
    wb_val_d  = wb_val_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          reglist_d = bus.reglist;
          base_d    = bus.base;
          p_d       = bus.p_bit;
          u_d       = bus.u_bit;
          w_d       = bus.w_bit;
          l_d       = bus.l_bit;
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        // Lowest address of the block; transfers always walk upwards from here.
        unique case ({p_q, u_q})
          2'b01:   addr_d = base_q;
          2'b11:   addr_d = base_q + WORD;
          2'b00:   addr_d = base_q - four_n + WORD;
          default: addr_d = base_q - four_n;
        endcase
        wb_val_d = u_q ? (base_q + four_n) : (base_q - four_n);
        cnt_d    = n_regs;
        state_d  = (n_regs == 5'd0) ? S_WB : S_XFER;
      end
      S_XFER: begin
        if (!bus.seq_busy) begin
          state_d = S_IDLE;
        end else begin
          addr_d = addr_q + WORD;
          cnt_d  = cnt_q - 5'd1;
          if (cnt_q == 5'd1) state_d = S_WB;
        end
      end
      S_WB: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (bus.flush && state_q != S_IDLE) state_d = S_IDLE;
  end

  // Sequencer running dry with transfers still owed ends the operation early without writeback.
  assign xfer_go = (state_q == S_XFER) && bus.seq_busy && !bus.flush;

  always_comb begin
    bus.seq_bits   = reglist_q;
    bus.seq_en     = (state_q == S_XFER);
    bus.busy       = (state_q != S_IDLE);
    bus.xfer_valid = xfer_go;
    bus.xfer_addr  = xfer_go ? addr_q : '0;
    bus.xfer_reg   = xfer_go ? bus.seq_cur : 4'd0;
    bus.xfer_load  = l_q;
    bus.xfer_last  = xfer_go && (cnt_q == 5'd1);
    bus.wb_en      = (state_q == S_WB) && w_q && !bus.flush;
    bus.wb_val     = (state_q == S_WB) ? wb_val_q : '0;
    bus.done       = !bus.flush &&
                     ((state_q == S_WB) || ((state_q == S_XFER) && !bus.seq_busy));
  end

endmodule

// File: tb/tb_ldm_agen.sv
// Directed bench for ldm_agen with a behavioural register-list sequencer in front of it.
module tb_ldm_agen;

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;

  ldm_agen_if #(.AW(32)) bus ();

  ldm_agen #(.AW(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Sequencer: reloads its mask while stalled, retires the lowest set bit on each advance.
  logic [15:0] mask;
  always @(posedge clk) begin
    if (!reset_n)        mask <= '0;
    else if (bus.seq_en) mask <= mask & (mask - 16'd1);
    else                 mask <= bus.seq_bits;
  end

  always_comb begin
    bus.seq_cur = 4'd0;
    for (int i = 15; i >= 0; i--) if (mask[i]) bus.seq_cur = 4'(i);
  end
  assign bus.seq_busy = |mask;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the rising edge that follows done.
  task automatic run_op(input string tag, input logic [15:0] rl, input logic [31:0] b,
                        input logic p, input logic u, input logic w, input logic l,
                        input logic [31:0] exp_first, input logic [31:0] exp_wb);
    int regs[$];
    int k;
    int t_last;
    bit got_done;
    for (int i = 0; i < 16; i++) if (rl[i]) regs.push_back(i);
    k = 0;
    t_last = -1;
    got_done = 0;
    bus.reglist = rl;
    bus.base    = b;
    bus.p_bit   = p;
    bus.u_bit   = u;
    bus.w_bit   = w;
    bus.l_bit   = l;
    bus.start   = 1'b1;
    for (int t = 0; t < 40 && !got_done; t++) begin
      @(negedge clk);
      if (t == 0) check({tag, " idle_at_start"}, 32'(bus.busy), 32'd0);
      if (bus.xfer_valid) begin
        if (k == 0) check({tag, " first_xfer_cycle"}, 32'(t), 32'd2);
        if (k < regs.size()) begin
          check($sformatf("%s reg%0d", tag, k), 32'(bus.xfer_reg), 32'(regs[k]));
          check($sformatf("%s addr%0d", tag, k), bus.xfer_addr, exp_first + 32'(4 * k));
          check($sformatf("%s last%0d", tag, k), 32'(bus.xfer_last), 32'(k == regs.size() - 1));
          check($sformatf("%s load%0d", tag, k), 32'(bus.xfer_load), 32'(l));
        end
        k++;
        t_last = t;
      end
      if (bus.done) begin
        got_done = 1;
        check({tag, " xfer_count"}, 32'(k), 32'(regs.size()));
        check({tag, " done_cycle"}, 32'(t), 32'((regs.size() == 0) ? 2 : t_last + 1));
        check({tag, " wb_en"}, 32'(bus.wb_en), 32'(w));
        check({tag, " wb_val"}, bus.wb_val, exp_wb);
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    if (!got_done) check({tag, " done_seen"}, 32'd0, 32'd1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " busy"},       32'(bus.busy),       32'd0);
    check({tag, " xfer_valid"}, 32'(bus.xfer_valid), 32'd0);
    check({tag, " xfer_addr"},  bus.xfer_addr,       32'd0);
    check({tag, " xfer_reg"},   32'(bus.xfer_reg),   32'd0);
    check({tag, " seq_bits"},   32'(bus.seq_bits),   32'd0);
    check({tag, " seq_en"},     32'(bus.seq_en),     32'd0);
    check({tag, " wb_en"},      32'(bus.wb_en),      32'd0);
    check({tag, " wb_val"},     bus.wb_val,          32'd0);
    check({tag, " done"},       32'(bus.done),       32'd0);
    check({tag, " xfer_last"},  32'(bus.xfer_last),  32'd0);
    check({tag, " xfer_load"},  32'(bus.xfer_load),  32'd0);
  endtask

  initial begin
    reset_n     = 1'b0;
    bus.start   = 1'b0;
    bus.reglist = '0;
    bus.base    = '0;
    bus.p_bit   = 1'b0;
    bus.u_bit   = 1'b0;
    bus.w_bit   = 1'b0;
    bus.l_bit   = 1'b0;
    bus.flush   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("ia_wb",    16'h000F, 32'h0000_1000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_1000, 32'h0000_1010);
    run_op("db_full",  16'hFFFF, 32'h0000_2000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_1FC0, 32'h0000_1FC0);
    run_op("empty",    16'h0000, 32'h0000_3000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_3000);
    run_op("ib_sparse",16'h8001, 32'h0000_0100, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0104, 32'h0000_0108);
    run_op("da_sparse",16'h8001, 32'h0000_0100, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_00FC, 32'h0000_00F8);
    run_op("db_wrap",  16'h0007, 32'h0000_0008, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);

    // Flush on the second transfer of 0x00F0, then relaunch the very next cycle.
    bus.reglist = 16'h00F0;
    bus.base    = 32'h0000_0400;
    bus.p_bit   = 1'b0;
    bus.u_bit   = 1'b1;
    bus.w_bit   = 1'b1;
    bus.l_bit   = 1'b1;
    bus.start   = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("flush xfer0 valid", 32'(bus.xfer_valid), 32'd1);
    check("flush xfer0 reg",   32'(bus.xfer_reg),   32'd4);
    check("flush xfer0 addr",  bus.xfer_addr,       32'h0000_0400);
    @(posedge clk); #1; bus.flush = 1'b1;
    @(negedge clk);
    check("flush cyc xfer_valid", 32'(bus.xfer_valid), 32'd0);
    check("flush cyc wb_en",      32'(bus.wb_en),      32'd0);
    check("flush cyc done",       32'(bus.done),       32'd0);
    @(posedge clk); #1; bus.flush = 1'b0;
    run_op("after_flush", 16'h00F0, 32'h0000_0400, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0400, 32'h0000_0410);

    // Stray starts while busy are ignored; reset mid-transfer abandons the operation.
    bus.reglist = 16'h0007;
    bus.base    = 32'h0000_0500;
    bus.p_bit   = 1'b0;
    bus.u_bit   = 1'b1;
    bus.w_bit   = 1'b1;
    bus.l_bit   = 1'b0;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.reglist = 16'h00F0;
    bus.base    = 32'h0000_0900;
    bus.p_bit   = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("stray xfer0 reg",  32'(bus.xfer_reg), 32'd0);
    check("stray xfer0 addr", bus.xfer_addr,     32'h0000_0500);
    @(posedge clk); #1;
    @(negedge clk);
    check("stray xfer1 reg",  32'(bus.xfer_reg), 32'd1);
    check("stray xfer1 addr", bus.xfer_addr,     32'h0000_0504);
    check("stray seq_bits",   32'(bus.seq_bits), 32'h0000_0007);
    @(posedge clk); #1;
    bus.start = 1'b0;
    reset_n   = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_quiet("mid_reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post_reset%0d done", i),  32'(bus.done),  32'd0);
      check($sformatf("post_reset%0d wb_en", i), 32'(bus.wb_en), 32'd0);
      check($sformatf("post_reset%0d busy", i),  32'(bus.busy),  32'd0);
      @(posedge clk); #1;
    end
    run_op("after_reset", 16'h0003, 32'h0000_0600, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_05FC, 32'h0000_05F8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
